// File: rtl/vm_pkg.sv
// Shared types and helpers for the multi-item vending controller.
package vm_pkg;

  typedef enum logic [1:0] {
    ACCEPT,
    VEND,
    CHANGE
  } state_e;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_1    = 2'b01;
  localparam logic [1:0] COIN_2    = 2'b10;
  localparam logic [1:0] COIN_3    = 2'b11;

  // Map a coin code onto its value; denominations come from the instantiating module.
  function automatic int unsigned coin_value(input logic [1:0] code,
                                             input int unsigned v1,
                                             input int unsigned v2,
                                             input int unsigned v3);
    int unsigned v;
    case (code)
      COIN_1:  v = v1;
      COIN_2:  v = v2;
      COIN_3:  v = v3;
      default: v = 0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/vm_change_gen.sv
// Greedy change selector: picks the largest coin not exceeding the credit.
// Assumes COIN3_VAL > COIN2_VAL > COIN1_VAL.
module vm_change_gen
  import vm_pkg::*;
#(
  parameter int unsigned CREDIT_W  = 8,
  parameter int unsigned COIN1_VAL = 5,
  parameter int unsigned COIN2_VAL = 10,
  parameter int unsigned COIN3_VAL = 25
) (
  input  logic [CREDIT_W-1:0] credit,
  output logic [1:0]          code,
  output logic [CREDIT_W-1:0] value
);

  // Largest-first coin choice for the current credit.
  always_comb begin
    code  = COIN_NONE;
    value = '0;
    if (credit >= CREDIT_W'(COIN3_VAL)) begin
      code  = COIN_3;
      value = CREDIT_W'(COIN3_VAL);
    end else if (credit >= CREDIT_W'(COIN2_VAL)) begin
      code  = COIN_2;
      value = CREDIT_W'(COIN2_VAL);
    end else if (credit >= CREDIT_W'(COIN1_VAL)) begin
      code  = COIN_1;
      value = CREDIT_W'(COIN1_VAL);
    end
  end

endmodule

// File: rtl/vending_machine_multi.sv
// Multi-item vending controller: coin crediting with overpay rejection,
// per-item stock, cancel/refund and greedy one-coin-per-cycle change.
module vending_machine_multi
  import vm_pkg::*;
#(
  parameter int unsigned NUM_ITEMS = 4,
  parameter int unsigned CREDIT_W  = 8,
  parameter int unsigned COIN1_VAL = 5,
  parameter int unsigned COIN2_VAL = 10,
  parameter int unsigned COIN3_VAL = 25,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES = {8'd40, 8'd25, 8'd20, 8'd15},
  parameter int unsigned MAX_CREDIT = 100,
  parameter int unsigned STOCK_MAX  = 7,
  parameter int unsigned IDX_W      = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [1:0]           in,
  input  logic                 sel_valid,
  input  logic [IDX_W-1:0]     sel,
  input  logic                 cancel,
  input  logic                 refill,
  input  logic [IDX_W-1:0]     refill_sel,
  output logic                 out,
  output logic [IDX_W-1:0]     out_item,
  output logic [1:0]           change,
  output logic [CREDIT_W-1:0]  credit,
  output logic                 busy,
  output logic                 err,
  output logic [NUM_ITEMS-1:0] sold_out
);

  localparam int unsigned SW       = $clog2(STOCK_MAX + 1);
  localparam bit          IDX_FULL = ((1 << IDX_W) == NUM_ITEMS);

  state_e               state_q, state_d;
  logic [CREDIT_W-1:0]  credit_q, credit_d;
  logic [SW-1:0]        stock_q [NUM_ITEMS];
  logic [SW-1:0]        stock_d [NUM_ITEMS];
  logic                 out_q, out_d;
  logic [IDX_W-1:0]     out_item_q, out_item_d;
  logic [1:0]           change_q, change_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;

  logic [CREDIT_W-1:0]  coin_val;
  logic [CREDIT_W-1:0]  coin_add;
  logic [CREDIT_W:0]    credit_plus_coin;
  logic                 coin_ok;
  logic                 coin_rej;
  logic [CREDIT_W-1:0]  price;
  logic                 sel_in_range;
  logic                 refill_in_range;
  logic [1:0]           gen_code;
  logic [CREDIT_W-1:0]  gen_val;

  vm_change_gen #(
    .CREDIT_W (CREDIT_W),
    .COIN1_VAL(COIN1_VAL),
    .COIN2_VAL(COIN2_VAL),
    .COIN3_VAL(COIN3_VAL)
  ) u_change_gen (
    .credit(credit_q),
    .code  (gen_code),
    .value (gen_val)
  );

  if (IDX_FULL) begin : g_idx_full
    assign sel_in_range    = 1'b1;
    assign refill_in_range = 1'b1;
  end else begin : g_idx_part
    assign sel_in_range    = (32'(sel) < NUM_ITEMS);
    assign refill_in_range = (32'(refill_sel) < NUM_ITEMS);
  end

  assign coin_val         = CREDIT_W'(coin_value(in, COIN1_VAL, COIN2_VAL, COIN3_VAL));
  assign credit_plus_coin = {1'b0, credit_q} + {1'b0, coin_val};
  assign coin_ok          = (in != COIN_NONE) && (credit_plus_coin <= (CREDIT_W+1)'(MAX_CREDIT));
  assign coin_rej         = (in != COIN_NONE) && !coin_ok;
  assign coin_add         = coin_ok ? coin_val : '0;
  assign price            = PRICES[sel*CREDIT_W +: CREDIT_W];

  // Next-state, credit, stock and output-register computation.
  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    stock_d    = stock_q;
    out_d      = 1'b0;
    out_item_d = out_item_q;
    change_d   = COIN_NONE;
    err_d      = 1'b0;

    case (state_q)
      ACCEPT: begin
        // A rejected coin goes straight back on the change output.
        if (coin_rej) change_d = in;
        if (cancel && (credit_q != '0)) begin
          state_d  = CHANGE;
          credit_d = credit_q + coin_add;
        end else if (sel_valid) begin
          // Selection is judged on credit before any same-cycle coin.
          if (!sel_in_range || (stock_q[sel] == '0) || (credit_q < price)) begin
            err_d    = 1'b1;
            credit_d = credit_q + coin_add;
          end else begin
            state_d      = VEND;
            credit_d     = credit_q - price + coin_add;
            out_d        = 1'b1;
            out_item_d   = sel;
            stock_d[sel] = stock_q[sel] - SW'(1);
          end
        end else begin
          credit_d = credit_q + coin_add;
        end
      end
      VEND: begin
        state_d = (credit_q != '0) ? CHANGE : ACCEPT;
      end
      CHANGE: begin
        change_d = gen_code;
        credit_d = credit_q - gen_val;
        if (gen_code == COIN_NONE) credit_d = '0;
        if (credit_d == '0) state_d = ACCEPT;
      end
      default: begin
        state_d  = ACCEPT;
        credit_d = '0;
      end
    endcase

    // Refill overrides a same-cycle vend decrement of the same item.
    if (refill && refill_in_range) stock_d[refill_sel] = SW'(STOCK_MAX);

    busy_d = (state_d != ACCEPT);
  end

  // State, credit, stock and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= ACCEPT;
      credit_q   <= '0;
      for (int unsigned i = 0; i < NUM_ITEMS; i++) stock_q[i] <= SW'(STOCK_MAX);
      out_q      <= 1'b0;
      out_item_q <= '0;
      change_q   <= COIN_NONE;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      stock_q    <= stock_d;
      out_q      <= out_d;
      out_item_q <= out_item_d;
      change_q   <= change_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  // Sold-out flags derived from the stock counters.
  always_comb begin
    sold_out = '0;
    for (int unsigned i = 0; i < NUM_ITEMS; i++) sold_out[i] = (stock_q[i] == '0);
  end

  assign out      = out_q;
  assign out_item = out_item_q;
  assign change   = change_q;
  assign credit   = credit_q;
  assign busy     = busy_q;
  assign err      = err_q;

  // Legal prices keep every residual credit a multiple of the smallest coin.
  a_change_residual : assert property (@(posedge clock) disable iff (!reset)
    (state_q == CHANGE) |-> (credit_q >= CREDIT_W'(COIN1_VAL)));

endmodule

// File: tb/tb_vending_machine_multi.sv
// Directed, table-driven bench for vending_machine_multi.
module tb_vending_machine_multi;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] in;
  logic       sel_valid;
  logic [1:0] sel;
  logic       cancel;
  logic       refill;
  logic [1:0] refill_sel;
  logic       out;
  logic [1:0] out_item;
  logic [1:0] change;
  logic [7:0] credit;
  logic       busy;
  logic       err;
  logic [3:0] sold_out;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0] coin;
    logic       sv;
    logic [1:0] s;
    logic       cn;
    logic       e_out;
    logic [1:0] e_item;
    logic [1:0] e_chg;
    logic [7:0] e_credit;
    logic       e_busy;
    logic       e_err;
  } vec_t;

  vec_t vq[$];

  vending_machine_multi dut (
    .clock     (clock),
    .reset     (reset),
    .in        (in),
    .sel_valid (sel_valid),
    .sel       (sel),
    .cancel    (cancel),
    .refill    (refill),
    .refill_sel(refill_sel),
    .out       (out),
    .out_item  (out_item),
    .change    (change),
    .credit    (credit),
    .busy      (busy),
    .err       (err),
    .sold_out  (sold_out)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] c, input logic sv, input logic [1:0] s, input logic cn,
                     input logic eo, input logic [1:0] ei, input logic [1:0] ec,
                     input logic [7:0] ecr, input logic eb, input logic ee);
    vec_t v;
    v.coin = c; v.sv = sv; v.s = s; v.cn = cn;
    v.e_out = eo; v.e_item = ei; v.e_chg = ec; v.e_credit = ecr; v.e_busy = eb; v.e_err = ee;
    vq.push_back(v);
  endtask

  task automatic drive(input logic [1:0] c, input logic sv, input logic [1:0] s, input logic cn);
    in = c; sel_valid = sv; sel = s; cancel = cn;
    tick();
    in = 2'b00; sel_valid = 1'b0; cancel = 1'b0;
  endtask

  function automatic int coin_amt(input logic [1:0] c);
    case (c)
      2'b01:   return 5;
      2'b10:   return 10;
      2'b11:   return 25;
      default: return 0;
    endcase
  endfunction

  initial begin
    int ncoins;
    int returned;
    logic [1:0] first_code;

    reset = 1'b0; in = 2'b00; sel_valid = 1'b0; sel = 2'd0; cancel = 1'b0;
    refill = 1'b0; refill_sel = 2'd0;

    // coin, sv, sel, cancel | out, item, change, credit, busy, err
    add(2'b10,0,0,0, 0,0,2'b00, 8'd10,0,0);
    add(2'b01,0,0,0, 0,0,2'b00, 8'd15,0,0);
    add(2'b00,1,0,0, 1,0,2'b00, 8'd0, 1,0);
    add(2'b00,0,0,0, 0,0,2'b00, 8'd0, 0,0);
    add(2'b11,0,0,0, 0,0,2'b00, 8'd25,0,0);
    add(2'b11,0,0,0, 0,0,2'b00, 8'd50,0,0);
    add(2'b00,1,2,0, 1,2,2'b00, 8'd25,1,0);
    add(2'b00,0,0,0, 0,0,2'b00, 8'd25,1,0);
    add(2'b00,0,0,0, 0,0,2'b11, 8'd0, 0,0);
    add(2'b00,0,0,0, 0,0,2'b00, 8'd0, 0,0);
    add(2'b10,0,0,0, 0,0,2'b00, 8'd10,0,0);
    add(2'b01,0,0,0, 0,0,2'b00, 8'd15,0,0);
    add(2'b00,0,0,1, 0,0,2'b00, 8'd15,1,0);
    add(2'b00,0,0,0, 0,0,2'b10, 8'd5, 1,0);
    add(2'b00,0,0,0, 0,0,2'b01, 8'd0, 0,0);
    add(2'b00,0,0,0, 0,0,2'b00, 8'd0, 0,0);
    add(2'b11,0,0,0, 0,0,2'b00, 8'd25,0,0);
    add(2'b11,0,0,0, 0,0,2'b00, 8'd50,0,0);
    add(2'b11,0,0,0, 0,0,2'b00, 8'd75,0,0);
    add(2'b10,0,0,0, 0,0,2'b00, 8'd85,0,0);
    add(2'b10,0,0,0, 0,0,2'b00, 8'd95,0,0);
    add(2'b11,0,0,0, 0,0,2'b11, 8'd95,0,0);
    add(2'b00,0,0,0, 0,0,2'b00, 8'd95,0,0);
    add(2'b00,0,0,1, 0,0,2'b00, 8'd95,1,0);
    add(2'b00,0,0,0, 0,0,2'b11, 8'd70,1,0);
    add(2'b00,0,0,0, 0,0,2'b11, 8'd45,1,0);
    add(2'b00,0,0,0, 0,0,2'b11, 8'd20,1,0);
    add(2'b00,0,0,0, 0,0,2'b10, 8'd10,1,0);
    add(2'b00,0,0,0, 0,0,2'b10, 8'd0, 0,0);
    add(2'b00,0,0,0, 0,0,2'b00, 8'd0, 0,0);
    add(2'b10,0,0,0, 0,0,2'b00, 8'd10,0,0);
    add(2'b01,1,0,0, 0,0,2'b00, 8'd15,0,1);
    add(2'b10,1,0,0, 1,0,2'b00, 8'd10,1,0);
    add(2'b00,0,0,0, 0,0,2'b00, 8'd10,1,0);
    add(2'b00,0,0,0, 0,0,2'b10, 8'd0, 0,0);
    add(2'b00,0,0,0, 0,0,2'b00, 8'd0, 0,0);

    // Reset for two cycles
    tick();
    tick();
    chk("reset.credit", credit, 0);
    chk("reset.change", change, 0);
    chk("reset.out", out, 0);
    chk("reset.busy", busy, 0);
    chk("reset.err", err, 0);
    chk("reset.sold_out", sold_out, 0);
    reset = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      in = vq[i].coin; sel_valid = vq[i].sv; sel = vq[i].s; cancel = vq[i].cn;
      tick();
      chk($sformatf("row%0d.out", i), out, vq[i].e_out);
      if (vq[i].e_out) chk($sformatf("row%0d.out_item", i), out_item, vq[i].e_item);
      chk($sformatf("row%0d.change", i), change, vq[i].e_chg);
      chk($sformatf("row%0d.credit", i), credit, vq[i].e_credit);
      chk($sformatf("row%0d.busy", i), busy, vq[i].e_busy);
      chk($sformatf("row%0d.err", i), err, vq[i].e_err);
      chk($sformatf("row%0d.sold_out", i), sold_out, 0);
    end
    in = 2'b00; sel_valid = 1'b0; cancel = 1'b0;

    // Drain item1 stock (price 20)
    for (int k = 0; k < 7; k++) begin
      drive(2'b10, 0, 0, 0);
      drive(2'b10, 0, 0, 0);
      drive(2'b00, 1, 1, 0);
      chk($sformatf("drain%0d.out", k), out, 1);
      chk($sformatf("drain%0d.out_item", k), out_item, 1);
      drive(2'b00, 0, 0, 0);
    end
    chk("drain.sold_out", sold_out, 4'b0010);

    drive(2'b10, 0, 0, 0);
    drive(2'b10, 0, 0, 0);
    drive(2'b00, 1, 1, 0);
    chk("soldout_sel.err", err, 1);
    chk("soldout_sel.out", out, 0);
    chk("soldout_sel.credit", credit, 20);
    drive(2'b00, 0, 0, 0);
    chk("soldout_sel.err_clear", err, 0);

    refill = 1'b1; refill_sel = 2'd1;
    tick();
    refill = 1'b0;
    chk("refill.sold_out", sold_out, 0);

    // Reset while refunding discards credit with no coin returned
    drive(2'b00, 0, 0, 1);
    chk("midreset.busy_before", busy, 1);
    reset = 1'b0;
    tick();
    chk("midreset.credit", credit, 0);
    chk("midreset.busy", busy, 0);
    chk("midreset.change", change, 0);
    reset = 1'b1;
    tick();
    chk("midreset.change_after", change, 0);

    // Refund of 30 with a bounded wait for the end of change
    drive(2'b11, 0, 0, 0);
    drive(2'b01, 0, 0, 0);
    drive(2'b00, 0, 0, 1);
    ncoins = 0; returned = 0; first_code = 2'b00;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (change != 2'b00) begin
        if (ncoins == 0) first_code = change;
        ncoins++;
        returned += coin_amt(change);
      end
      if (!busy) break;
    end
    chk("refund30.done", busy, 0);
    chk("refund30.ncoins", ncoins, 2);
    chk("refund30.first", first_code, 2'b11);
    chk("refund30.total", returned, 30);
    chk("refund30.credit", credit, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
